// File: rtl/riscv_dec_exe_mem.sv
// Single-cycle RV32 datapath slice: register file with immediate decode,
// ALU with operand-B mux, and word-addressed data memory. All outputs are
// combinational; register and memory writes land on the rising clock edge.
module riscv_dec_exe_mem #(
    parameter int DM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic [31:0] wd,
    input  logic        RegWrite,
    input  logic        ALUSrc,
    input  logic [2:0]  op,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] imm,
    output logic [31:0] jTarget,
    output logic [31:0] branch,
    output logic [31:0] z,
    output logic        zero,
    output logic [31:0] memOut
);

    localparam int AW = $clog2(DM_WORDS);

    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    logic [31:0]   regs_q [32];
    logic [31:0]   regs_d [32];
    logic [31:0]   mem_q  [DM_WORDS];
    logic [4:0]    rs1, rs2, rd;
    logic [31:0]   alu_b;
    logic [AW-1:0] dm_idx;

    assign rs1 = ins[19:15];
    assign rs2 = ins[24:20];
    assign rd  = ins[11:7];

    // Register-file next state: one word updated on a write, x0 never written.
    always_comb begin
        // NOTE: default every comb output first, otherwise a missed branch infers a latch.
        regs_d = regs_q;
        if (RegWrite && rd != 5'd0) begin
            regs_d[rd] = wd;
        end
    end

    // Register-file state with asynchronous clear; clear also blocks writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
            regs_q <= '{default: 32'h0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Asynchronous reads, no bypass: a same-edge write shows up after the edge.
    always_comb begin
        rd1 = (rs1 == 5'd0) ? 32'h0 : regs_q[rs1];
        rd2 = (rs2 == 5'd0) ? 32'h0 : regs_q[rs2];
    end

    // Immediate decode; branch and jump offsets are always driven.
    always_comb begin
        branch  = {{20{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8]};
        jTarget = {{12{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21]};
        unique case (ins[6:0])
            OPC_STORE:  imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OPC_BRANCH: imm = branch;
            default:    imm = {{20{ins[31]}}, ins[31:20]};
        endcase
    end

    // ALU: A is always rd1, B selects between immediate and rd2.
    always_comb begin
        alu_b = ALUSrc ? imm : rd2;
        case (alu_op_e'(op))
            ALU_AND: z = rd1 & alu_b;
            ALU_OR:  z = rd1 | alu_b;
            ALU_ADD: z = rd1 + alu_b;
            ALU_SUB: z = rd1 - alu_b;
            ALU_SLT: z = ($signed(rd1) < $signed(alu_b)) ? 32'h1 : 32'h0;
            default: z = 32'h0;
        endcase
        zero = (z == 32'h0);
    end

    // Word index from the ALU result; byte offset and upper bits wrap away.
    assign dm_idx = z[AW+1:2];

    // Combinational read, gated to zero when not reading.
    assign memOut = MemRead ? mem_q[dm_idx] : 32'h0;

    // Data-memory write; contents survive reset, but writes are held off during it.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays carry no reset so they map onto RAM; rst_n only gates the write.
        if (rst_n && MemWrite) begin
            mem_q[dm_idx] <= rd2;
        end
    end

endmodule

// File: tb/tb_riscv_dec_exe_mem.sv
// Scoreboard bench for riscv_dec_exe_mem: the stimulus process drives one
// vector per cycle just after the rising edge and queues the expected outputs;
// the monitor pops and compares them on the following falling edge.
module tb_riscv_dec_exe_mem;

    typedef enum int { S_RD1, S_RD2, S_IMM, S_JT, S_BR, S_Z, S_ZERO, S_MEM } sel_e;

    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ins, wd;
    logic        RegWrite, ALUSrc, MemRead, MemWrite;
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm, jTarget, branch, z, memOut;
    logic        zero;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    riscv_dec_exe_mem #(.DM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .wd(wd), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .op(op), .MemRead(MemRead), .MemWrite(MemWrite),
        .rd1(rd1), .rd2(rd2), .imm(imm), .jTarget(jTarget), .branch(branch),
        .z(z), .zero(zero), .memOut(memOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    // sw x7, -4(x5): rd field bits happen to be 5'b11100 (x28)
    localparam logic [31:0] SW_INS = {7'h7F, 5'd7, 5'd5, 3'b010, 5'b11100, 7'h23};

    function automatic logic [31:0] get_act(input sel_e s);
        case (s)
            S_RD1:   return rd1;
            S_RD2:   return rd2;
            S_IMM:   return imm;
            S_JT:    return jTarget;
            S_BR:    return branch;
            S_Z:     return z;
            S_ZERO:  return {31'h0, zero};
            default: return memOut;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = s;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    // Advance to just after the next rising edge and clear the controls.
    task automatic step();
        @(posedge clk);
        #1;
        RegWrite = 1'b0; ALUSrc = 1'b0; op = 3'b000;
        MemRead = 1'b0; MemWrite = 1'b0; wd = 32'h0;
    endtask

    task automatic reg_write(input logic [4:0] r, input logic [31:0] v);
        step();
        ins = mk_r(r, 5'd0, 5'd0);
        RegWrite = 1'b1;
        wd = v;
    endtask

    // Monitor: compare everything queued for this cycle mid-period.
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.name, get_act(e.sel), e.exp);
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0; ins = 32'h0; wd = 32'h0; RegWrite = 1'b0; ALUSrc = 1'b0;
        op = 3'b000; MemRead = 1'b0; MemWrite = 1'b0;

        step();
        ins = mk_r(5'd0, 5'd5, 5'd5);
        expect_out("reset_rd1", S_RD1, 32'h0);
        expect_out("reset_rd2", S_RD2, 32'h0);

        step();
        rst_n = 1'b1;
        ins = mk_r(5'd5, 5'd5, 5'd0); RegWrite = 1'b1; wd = 32'd7;
        expect_out("no_bypass", S_RD1, 32'h0);

        step();
        ins = mk_r(5'd0, 5'd5, 5'd0); RegWrite = 1'b1; wd = 32'd9;
        expect_out("x5_written", S_RD1, 32'd7);

        step();
        ins = mk_r(5'd0, 5'd0, 5'd5);
        expect_out("x0_ignored", S_RD1, 32'h0);
        expect_out("x5_on_rd2", S_RD2, 32'd7);

        step();
        ins = 32'h00A28293; ALUSrc = 1'b1; op = 3'b010;
        expect_out("addi_imm", S_IMM, 32'd10);
        expect_out("addi_z", S_Z, 32'd17);
        expect_out("addi_zero", S_ZERO, 32'h0);

        step();
        ins = 32'h00A28293; ALUSrc = 1'b1; op = 3'b110;
        expect_out("sub_imm_z", S_Z, 32'hFFFF_FFFD);

        reg_write(5'd6, 32'd5);
        reg_write(5'd8, 32'hFFFF_FFFF);
        reg_write(5'd9, 32'd1);
        reg_write(5'd10, 32'h0000_00F0);
        reg_write(5'd11, 32'h0000_003C);

        step();
        ins = mk_r(5'd0, 5'd6, 5'd6); op = 3'b110;
        expect_out("sub_eq_z", S_Z, 32'h0);
        expect_out("sub_eq_zero", S_ZERO, 32'h1);

        step();
        ins = mk_r(5'd0, 5'd8, 5'd9); op = 3'b111;
        expect_out("slt_neg", S_Z, 32'h1);

        step();
        ins = mk_r(5'd0, 5'd9, 5'd8); op = 3'b111;
        expect_out("slt_pos", S_Z, 32'h0);

        step();
        ins = mk_r(5'd0, 5'd10, 5'd11); op = 3'b000;
        expect_out("and", S_Z, 32'h30);

        step();
        ins = mk_r(5'd0, 5'd10, 5'd11); op = 3'b001;
        expect_out("or", S_Z, 32'hFC);

        step();
        ins = mk_r(5'd0, 5'd10, 5'd11); op = 3'b010;
        expect_out("add_rr", S_Z, 32'h12C);

        step();
        ins = mk_r(5'd0, 5'd10, 5'd11); op = 3'b011;
        expect_out("op_undef", S_Z, 32'h0);

        step();
        ins = mk_r(5'd0, 5'd8, 5'd9); op = 3'b010;
        expect_out("add_wrap", S_Z, 32'h0);

        reg_write(5'd5, 32'd20);
        reg_write(5'd7, 32'h0000_1234);

        // store plus a simultaneous register write to x28
        step();
        ins = SW_INS; ALUSrc = 1'b1; op = 3'b010; MemWrite = 1'b1;
        RegWrite = 1'b1; wd = 32'h0000_ABCD;
        expect_out("sw_imm", S_IMM, 32'hFFFF_FFFC);
        expect_out("sw_z", S_Z, 32'd16);
        expect_out("sw_rd2", S_RD2, 32'h1234);
        expect_out("memout_gated", S_MEM, 32'h0);

        step();
        ins = SW_INS; ALUSrc = 1'b1; op = 3'b010; MemRead = 1'b1;
        expect_out("lw_after_sw", S_MEM, 32'h1234);

        step();
        ins = mk_r(5'd0, 5'd28, 5'd0);
        expect_out("regwr_with_sw", S_RD1, 32'h0000_ABCD);

        reg_write(5'd7, 32'h0000_5678);

        step();
        ins = SW_INS; ALUSrc = 1'b1; op = 3'b010; MemRead = 1'b1; MemWrite = 1'b1;
        expect_out("rw_old_word", S_MEM, 32'h1234);

        step();
        ins = SW_INS; ALUSrc = 1'b1; op = 3'b010; MemRead = 1'b1;
        expect_out("rw_new_word", S_MEM, 32'h5678);

        // addr 20 + 1023 = 1043 -> word index 260 mod 256 = 4
        step();
        ins = {12'd1023, 5'd5, 3'b010, 5'd0, 7'h03}; ALUSrc = 1'b1; op = 3'b010; MemRead = 1'b1;
        expect_out("wrap_z", S_Z, 32'd1043);
        expect_out("wrap_mem", S_MEM, 32'h5678);

        step();
        ins = 32'hFE000EE3;
        expect_out("b_branch", S_BR, 32'hFFFF_FFFE);
        expect_out("b_imm", S_IMM, 32'hFFFF_FFFE);

        step();
        ins = 32'h0080006F;
        expect_out("j_target", S_JT, 32'd4);

        step();
        ins = 32'hFFF00013;
        expect_out("i_imm", S_IMM, 32'hFFFF_FFFF);

        // async reset between edges; a store to word 4 is attempted while held
        step();
        rst_n = 1'b0;
        ins = {12'd16, 5'd0, 3'b000, 5'd0, 7'h03}; ALUSrc = 1'b1; op = 3'b010;
        MemRead = 1'b1; MemWrite = 1'b1;
        expect_out("async_rst_rd1", S_RD1, 32'h0);
        expect_out("async_rst_z", S_Z, 32'd16);

        step();
        rst_n = 1'b1;
        ins = {12'd16, 5'd0, 3'b000, 5'd0, 7'h03}; ALUSrc = 1'b1; op = 3'b010; MemRead = 1'b1;
        expect_out("mem_retained", S_MEM, 32'h5678);

        step();
        ins = mk_r(5'd0, 5'd5, 5'd7);
        expect_out("rst_cleared_x5", S_RD1, 32'h0);
        expect_out("rst_cleared_x7", S_RD2, 32'h0);

        // let the monitor drain, bounded
        begin
            int waited = 0;
            while (sb_q.size() > 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
        end
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_dec_exe_mem.md
Name: riscv_dec_exe_mem

Overview:
- Single-cycle RV32 datapath slice containing three stages:
  - decode: register file and immediate generation
  - execute: ALU with operand mux
  - data memory
- Sits between the fetch stage (supplies the instruction word) and the write-back mux (supplies the register write data).
- All datapath outputs are combinational. Register file and data memory writes occur on the rising edge of clk.

Parameters:
- DM_WORDS, 256, data-memory depth in 32-bit words; must be a power of two.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ins  in  32  current instruction word.
- wd  in  32  register write-back data.
- RegWrite  in  1  register file write enable.
- ALUSrc  in  1  ALU operand B select: 1 = imm, 0 = rd2.
- op  in  3  ALU operation select.
- MemRead  in  1  data memory read enable.
- MemWrite  in  1  data memory write enable.
- rd1  out  32  register file read port 1, addressed by rs1 = ins[19:15].
- rd2  out  32  register file read port 2, addressed by rs2 = ins[24:20].
- imm  out  32  sign-extended immediate selected by opcode.
- jTarget  out  32  sign-extended J-type offset, in halfwords.
- branch  out  32  sign-extended B-type offset, in halfwords.
- z  out  32  ALU result; also the data memory address.
- zero  out  1  high when z == 0.
- memOut  out  32  data memory read data.

Behaviour:
- Reset:
  - Asynchronous assertion of rst_n low clears all 32 registers to 0.
  - Data memory contents are not reset.
  - All outputs are combinational functions of state and inputs, so after reset rd1 = rd2 = 0.
- Register file (32 x 32):
  - x0 always reads 0; writes to x0 are ignored.
  - Write: at posedge clk when RegWrite = 1 and rst_n = 1, reg[ins[11:7]] <= wd.
  - Reads are asynchronous, with no write-through bypass: a value written at an edge is visible after that edge.
- Immediate (opcode = ins[6:0]):
  - 0x23 (S-type): imm = sext({ins[31:25], ins[11:7]}).
  - 0x63 (B-type): imm = branch.
  - All other opcodes: imm = sext(ins[31:20]) (I-type).
- branch = sext({ins[31], ins[7], ins[30:25], ins[11:8]}), a 12-bit halfword offset. It is always driven, regardless of opcode.
- jTarget = sext({ins[31], ins[19:12], ins[20], ins[30:21]}), a 20-bit halfword offset. It is always driven, regardless of opcode.
- ALU operands: A = rd1; B = ALUSrc ? imm : rd2.
- ALU operation by op:
  - 000: A & B.
  - 001: A | B.
  - 010: A + B.
  - 110: A - B.
  - 111: signed A < B yields 1, else 0.
  - Any other value: 0.
- ALU arithmetic wraps modulo 2^32; no overflow flag.
- zero = (z == 32'h0).
- Data memory (DM_WORDS x 32):
  - Word index = z[log2(DM_WORDS)+1 : 2]. Byte-offset bits z[1:0] and bits above the index are ignored, so addresses wrap.
  - Read: memOut = mem[index] when MemRead = 1, else 0. The read is combinational.
  - Write: at posedge clk when MemWrite = 1 and rst_n = 1, mem[index] <= rd2.
  - Simultaneous MemRead and MemWrite: before the edge, memOut returns the old word; after the edge, it returns the new word.
- Simultaneous RegWrite and MemWrite in one cycle are independent; both take effect at the same edge.
- Reset mid-operation:
  - Registers clear immediately.
  - While rst_n is low, register and memory writes are suppressed.
  - In-flight memory contents are retained.

Test Plan:
- Reset, then read x5 -> rd1 = 0. Apply RegWrite=1, ins rd=5, wd=32'd7, clock edge -> rs1=5 reads 7. Write wd=9 to x0 -> x0 still reads 0.
- addi-type ins 0x00A28293 (x5 = 7), ALUSrc=1, op=010 -> imm=10, z=17, zero=0. Same ins with op=110 -> z=-3 (0xFFFFFFFD).
- R-type with rd1=5, rd2=5, ALUSrc=0, op=110 -> z=0, zero=1. op=111 with rd1=-1, rd2=1 -> z=1. op=000/001 with 0xF0 and 0x3C -> 0x30 / 0xFC.
- sw ins opcode 0x23, imm=-4, rs1=20, rs2=7: set x5=20 (reg[ins[19:15]]) and x7=0x1234. MemWrite=1, op=010, clock edge -> mem[4] = 0x1234. Then MemRead=1 at address 16 -> memOut = 0x1234. MemRead=0 -> memOut = 0.
- Immediate decode: B-type ins 0xFE000EE3 -> branch = imm = -2. J-type ins 0x0080006F -> jTarget = 4. I-type 0xFFF00013 -> imm = -1.
- Assert rst_n low asynchronously between clock edges -> all registers read 0 immediately. A previously written memory word is still returned after rst_n is released.
